// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, long-latency
// results are parked in a small FIFO, drained into idle slots, and forced through with a bubble if starved.
`timescale 1ns/1ps
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        stall_req,
  output logic        protocol_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  logic [4:0]  mem_rd   [DEPTH];
  logic [31:0] mem_data [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [1:0]  state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, cnt_inc;
  logic        full, empty, empty_nxt;
  logic        pipe_wr, push, pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign lu_ready = !full;

  // Writes to x0 are architecturally void, so they leave the slot free for a drain.
  assign pipe_wr = RegWriteW && (RdW != 5'd0);
  assign push    = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign pop     = !pipe_wr && !empty;

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
  assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
  assign cnt_inc    = cnt + 4'd1;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    if (pipe_wr) begin
      rf_we    = 1'b1;
      rf_waddr = RdW;
      rf_wdata = ResultW;
    end else if (!empty) begin
      rf_we    = 1'b1;
      rf_waddr = mem_rd[rd_ptr[AW-1:0]];
      rf_wdata = mem_data[rd_ptr[AW-1:0]];
    end
  end

  // NOTE: every variable gets a default first so no path through this block infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        cnt_nxt = 4'd0;
        if (!empty_nxt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (pop) begin
          cnt_nxt   = 4'd0;
          state_nxt = empty_nxt ? S_IDLE : S_WAIT;
        end else if (cnt_inc == LIMIT) begin
          cnt_nxt   = 4'd0;
          state_nxt = S_FORCE;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      S_FORCE: begin
        if (pop) begin
          cnt_nxt   = 4'd0;
          state_nxt = empty_nxt ? S_IDLE : S_WAIT;
        end
      end
      default: begin
        cnt_nxt   = 4'd0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      state        <= S_IDLE;
      cnt          <= 4'd0;
      stall_req    <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stall_req <= (state_nxt == S_FORCE);
      if (stall_req && pipe_wr) protocol_err <= 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wr_ptr[AW-1:0]]   <= lu_rd;
      mem_data[wr_ptr[AW-1:0]] <= lu_data;
    end
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback (ResultW from the writeback stage) and an out-of-band long-latency unit such as a multiplier/divider. Pipeline writes always win the port. Long-latency results are parked in a small FIFO and drained into idle write slots. If a parked result waits too long, the block requests a one-cycle pipeline bubble to guarantee forward progress.

## Interface
Parameters:
- DEPTH, 2: FIFO entries for parked results; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive cycles a non-empty FIFO head may go undrained before a bubble is requested; range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- RegWriteW  in  1  pipeline writeback write enable.
- RdW  in  5  pipeline destination register.
- ResultW  in  32  pipeline writeback data (writeback-stage mux output).
- lu_valid  in  1  long-latency unit has a result.
- lu_rd  in  5  long-latency destination register.
- lu_data  in  32  long-latency result data.
- lu_ready  out  1  block accepts a result this cycle; equals !full.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  32  register-file write data.
- stall_req  out  1  registered; hazard unit must insert a W-stage bubble this cycle.
- protocol_err  out  1  sticky; set when the pipeline writes while stall_req=1.

## Operation
- Push: lu_valid && lu_ready at a rising edge.
  - If lu_rd != 0, append {lu_rd, lu_data} to the FIFO tail.
  - If lu_rd == 0, accept and discard; the FIFO is unchanged.
- Port selection is combinational from current-cycle inputs and the FIFO head:
  - pipe_wr = RegWriteW && RdW != 0. If set, rf_we=1, rf_waddr=RdW, rf_wdata=ResultW.
  - Otherwise, if the FIFO is non-empty, rf_we=1 with the head's rd/data. This is a pop at the edge.
  - Otherwise rf_we=0, rf_waddr=0, rf_wdata=0.
- A pipeline write to x0 counts as a free slot and never blocks a drain.
- State machine, with starve counter cnt (4 bits):
  - IDLE: FIFO empty, cnt=0. Go to WAIT at the edge where the FIFO becomes non-empty.
  - WAIT, head not popped this cycle: cnt+1. When cnt+1 == STARVE_LIMIT, go to FORCE and set stall_req=1 for the next cycle.
  - WAIT, head popped this cycle: cnt=0. Stay in WAIT if the FIFO remains non-empty, else go to IDLE.
  - FORCE: stall_req=1 and the head is popped.
    - If pipe_wr is also 1, the pipeline still wins, protocol_err is set, and the block stays in FORCE.
    - Otherwise the head pops. cnt=0; go to WAIT if the FIFO is still non-empty, else IDLE.
- Push and pop in the same cycle are legal when not full; occupancy is unchanged.
- When full, lu_ready=0, even if a pop occurs that cycle.
- Write ordering between a parked result and a later pipeline write to the same rd is the hazard unit's responsibility. This block always drains in FIFO order.

## Timing
- Reset values (asynchronous, while rst=0):
  - FIFO empty, state IDLE, cnt=0.
  - stall_req=0, protocol_err=0, lu_ready=1.
  - rf_we follows the inputs combinationally; with RegWriteW=0 it is 0.
- Push-to-visible latency: a result pushed at edge N can appear on the rf_* outputs in cycle N+1 at the earliest. There is no same-cycle bypass from lu_* to rf_*.
- Worst-case drain latency from becoming FIFO head to write: STARVE_LIMIT+1 cycles (STARVE_LIMIT waiting cycles plus the FORCE cycle), given a compliant pipeline.
- stall_req is high for exactly one cycle per FORCE entry unless a protocol error extends it.
- Pointers are log2(DEPTH) bits plus one wrap bit.
  - full: pointers equal except the wrap bit.
  - empty: pointers fully equal.
- Reset asserted mid-operation discards parked results immediately. No rf write occurs for them.

## Test plan
- Reset, then idle for 3 cycles -> rf_we=0, lu_ready=1, stall_req=0, protocol_err=0.
- Push lu_rd=5/0xDEADBEEF with RegWriteW=0 -> in the next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; FIFO returns to empty.
- Push two results with the pipeline writing RdW=7 every cycle, STARVE_LIMIT=4 -> 4 cycles later stall_req=1 for 1 cycle. Drive RegWriteW=0 in that cycle -> the first parked result is written. After 4 more cycles stall_req pulses again and the second result drains.
- Fill 2 entries while the pipeline is busy -> lu_ready=0. Pipeline writes RdW=0 -> the head drains, and lu_ready=1 in the following cycle.
- Push with lu_rd=0 -> accepted, FIFO stays empty, no rf write.
- Hold RegWriteW=1, RdW=3 during a stall_req cycle -> protocol_err=1 and stays set until reset. Assert rst mid-stall -> all state is cleared asynchronously.
